pe_dr_param: RTL and testbench
==============================

# pe_dr_param

Parametrised successor of the door-register processing element for the CGRA array. It keeps the PE datapath: operand select, ALU and switch element. It adds five things: configurable data width, a per-output door register of programmable latency (0–3 cycles) on all four directional outputs and on DL_N/DL_NN, a programmable-depth delay line on DL_NN, an accumulate ALU mode, and a latched configuration with array-wide stall. It sits in every array cell; neighbours connect through the directional and DL ports.

## Interface
- DATA_W, 16, datapath width in bits (≥4).
- DL_DEPTH, 4, maximum DL_NN delay-line depth in cycles (≥1).
- DLW, $clog2(DL_DEPTH+1), width of conf_dl (derived, not overridden).

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  freezes all data registers: doors, delay line, accumulator.
- conf_we  in  1  latches all conf_* inputs into the active configuration.
- conf_alu  in  4  ALU opcode.
- conf_sel_a, conf_sel_b  in  3 each  operand selects.
- conf_se  in  8  switch codes, 2 bits each; [1:0] N, [3:2] S, [5:4] E, [7:6] W.
- conf_dr  in  12  door latency, 2 bits each; order N, S, E, W, DL_N, DL_NN from LSB.
- conf_dl  in  DLW  DL_NN delay-line depth.
- IN_NORTH, IN_SOUTH, IN_EAST, IN_WEST, IN_DL_S, IN_DL_W, IN_DL_SS, IN_CONST_A, IN_CONST_B  in  DATA_W  data inputs.
- OUT_NORTH, OUT_SOUTH, OUT_EAST, OUT_WEST, OUT_DL_N, OUT_DL_E, OUT_DL_NN  out  DATA_W  data outputs.

## Operation
- Active config registers (cfg_*) load from conf_* on any edge with conf_we=1; reset value is all zero. Only cfg_* drives the datapath.
- Operand select, same codes for A and B: 0 S, 1 E, 2 W, 3 DL_S, 4 DL_W, 5 DL_SS, 6 CONST_A, 7 CONST_B.
- ALU, all results modulo 2^DATA_W:
  - 0 zero; 1 A+B; 2 A−B; 3 A*B (low DATA_W bits).
  - 4 AND; 5 OR; 6 XOR.
  - 7 A<<B[log2(DATA_W)-1:0]; 8 logical right shift; 9 arithmetic right shift.
  - 10 pass A; 11 ACC = acc_q+A; 12 signed max; 13 signed min; 14–15 zero.
- Accumulator acc_q, DATA_W bits:
  - Loads ALU_OUT on an edge with cfg_alu=11, stall=0, conf_we=0.
  - Cleared by rst and by conf_we.
  - Holds in all other cases.
- Switch element, per direction: 0 zero, 1 ALU_OUT, 2 pass the opposite input (N←IN_SOUTH, S←IN_NORTH, E←IN_WEST, W←IN_EAST), 3 IN_CONST_A.
- DL_N source is ALU_OUT. DL_E is ALU_OUT, combinational, with no door.
- DL_NN source is ALU_OUT delayed by cfg_dl cycles through a DL_DEPTH-stage shift register.
  - cfg_dl=0 bypasses the shift register.
  - cfg_dl>DL_DEPTH saturates to DL_DEPTH.
  - The register shifts only when stall=0.
- Door, per output: a chain of 3 registers. The output taps the chain at stage cfg_dr, where 0 means combinational bypass. The chain shifts only when stall=0.
- conf_we clears every door stage, delay-line stage and acc_q in the same edge that loads the new config. conf_we has priority over stall.
- Reset: all config, door, delay-line and acc registers go to 0. Every output is therefore 0 after reset and until configured: all-zero config means op zero, SE code zero, door bypass.

## Timing
- Input→output latency equals the door latency cfg_dr (0–3). OUT_DL_NN latency is cfg_dl (saturated) + cfg_dr.
- The new configuration takes effect in the cycle after the conf_we edge.
- Registered outputs read 0 for the first cfg_dr (+cfg_dl) cycles after conf_we.
- Stall: registered outputs hold their values exactly. Bypass outputs and OUT_DL_E still follow inputs combinationally. Data is neither lost nor duplicated across a stall; the sequence is resumed cycle-for-cycle.
- rst asserted mid-operation: outputs go to 0 immediately, with no clock needed. Operation resumes on the first edge after rst deasserts, with all-zero config.
- conf_we and stall both high: the config loads and the flush happens, and stall is ignored for that edge.

## Test plan
- Reset: assert rst with random inputs. All 7 outputs read 0 asynchronously and stay 0 after release with no config.
- ADD, S=5, E=7 (sel_a=0, sel_b=1, se N=1, dr N=2): OUT_NORTH=12 exactly 2 edges after the inputs are applied. OUT_DL_E=12 combinationally.
- Wrap and shift, DATA_W=16: 0xFFFF+0x0002 → 0x0001. SRA of 0x8000 by 3 → 0xF000. MUL 0x0100*0x0100 → 0x0000.
- ACC with CONST_A=3: after conf_we, acc after N edges = 3N. Stall for 4 cycles holds the value. A second conf_we clears it to 0.
- DL_NN with conf_dl=7, DL_DEPTH=4, dr DL_NN=1: an impulse 0x00AA on ALU_OUT appears on OUT_DL_NN after 5 edges, for one cycle.
- Stall mid-stream with N door latency 3 and a counter stream 1,2,3…: the output sequence has no gaps or repeats beyond held cycles. A stall asserted together with conf_we still flushes all door stages to 0.

Source files
------------

// File: rtl/pe_dr_param.sv
// CGRA processing element with a programmable per-output door latency, a DL_NN delay line,
// an accumulate mode, a latched configuration and an array-wide stall.
module pe_dr_param #(
  parameter  int DATA_W   = 16,
  parameter  int DL_DEPTH = 4,
  localparam int DLW      = $clog2(DL_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              conf_we,
  input  logic [3:0]        conf_alu,
  input  logic [2:0]        conf_sel_a,
  input  logic [2:0]        conf_sel_b,
  input  logic [7:0]        conf_se,
  input  logic [11:0]       conf_dr,
  input  logic [DLW-1:0]    conf_dl,
  input  logic [DATA_W-1:0] IN_NORTH,
  input  logic [DATA_W-1:0] IN_SOUTH,
  input  logic [DATA_W-1:0] IN_EAST,
  input  logic [DATA_W-1:0] IN_WEST,
  input  logic [DATA_W-1:0] IN_DL_S,
  input  logic [DATA_W-1:0] IN_DL_W,
  input  logic [DATA_W-1:0] IN_DL_SS,
  input  logic [DATA_W-1:0] IN_CONST_A,
  input  logic [DATA_W-1:0] IN_CONST_B,
  output logic [DATA_W-1:0] OUT_NORTH,
  output logic [DATA_W-1:0] OUT_SOUTH,
  output logic [DATA_W-1:0] OUT_EAST,
  output logic [DATA_W-1:0] OUT_WEST,
  output logic [DATA_W-1:0] OUT_DL_N,
  output logic [DATA_W-1:0] OUT_DL_E,
  output logic [DATA_W-1:0] OUT_DL_NN
);

  localparam int SHW   = $clog2(DATA_W);
  localparam int NDOOR = 6;
  localparam int D_N   = 0;
  localparam int D_S   = 1;
  localparam int D_E   = 2;
  localparam int D_W   = 3;
  localparam int D_DLN = 4;
  localparam int D_DNN = 5;

  localparam logic [DLW-1:0] DL_MAX = DLW'(DL_DEPTH);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_PAS = 4'd10;
  localparam logic [3:0] OP_ACC = 4'd11;
  localparam logic [3:0] OP_MAX = 4'd12;
  localparam logic [3:0] OP_MIN = 4'd13;

  // Depths beyond the physical delay line clamp to its full length.
  function automatic logic [DLW-1:0] sat_dl(input logic [DLW-1:0] d);
    return (d > DL_MAX) ? DL_MAX : d;
  endfunction

  function automatic logic [DATA_W-1:0] se_mux(input logic [1:0]        code,
                                               input logic [DATA_W-1:0] alu,
                                               input logic [DATA_W-1:0] opp,
                                               input logic [DATA_W-1:0] ca);
    case (code)
      2'd1:    return alu;
      2'd2:    return opp;
      2'd3:    return ca;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] door_tap(input logic [1:0]        lat,
                                                 input logic [DATA_W-1:0] d0,
                                                 input logic [DATA_W-1:0] d1,
                                                 input logic [DATA_W-1:0] d2,
                                                 input logic [DATA_W-1:0] d3);
    case (lat)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  logic [3:0]        cfg_alu;
  logic [2:0]        cfg_sel_a;
  logic [2:0]        cfg_sel_b;
  logic [7:0]        cfg_se;
  logic [11:0]       cfg_dr;
  logic [DLW-1:0]    cfg_dl;

  logic [7:0][DATA_W-1:0]   src;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] alu_out;
  logic signed [DATA_W-1:0] acc_q;
  logic [SHW-1:0]           shamt;

  logic [DLW-1:0]                 dl_sat;
  logic [DL_DEPTH-1:0][DATA_W-1:0] dl_q;
  logic [DATA_W-1:0]              dl_out;

  logic [NDOOR-1:0][DATA_W-1:0] door_in;
  logic [NDOOR-1:0][DATA_W-1:0] door_p0;
  logic [NDOOR-1:0][DATA_W-1:0] door_p1;
  logic [NDOOR-1:0][DATA_W-1:0] door_p2;
  logic [NDOOR-1:0][DATA_W-1:0] door_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_alu   <= '0;
      cfg_sel_a <= '0;
      cfg_sel_b <= '0;
      cfg_se    <= '0;
      cfg_dr    <= '0;
      cfg_dl    <= '0;
    end else if (conf_we) begin
      cfg_alu   <= conf_alu;
      cfg_sel_a <= conf_sel_a;
      cfg_sel_b <= conf_sel_b;
      cfg_se    <= conf_se;
      cfg_dr    <= conf_dr;
      cfg_dl    <= conf_dl;
    end
  end

  // Stage: operand select and ALU (combinational)
  assign src   = {IN_CONST_B, IN_CONST_A, IN_DL_SS, IN_DL_W, IN_DL_S, IN_WEST, IN_EAST, IN_SOUTH};
  assign op_a  = $signed(src[cfg_sel_a]);
  assign op_b  = $signed(src[cfg_sel_b]);
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (cfg_alu)
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_MUL:  alu_out = op_a * op_b;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_SHL:  alu_out = op_a << shamt;
      OP_SHR:  alu_out = op_a >> shamt;
      OP_SRA:  alu_out = op_a >>> shamt;
      OP_PAS:  alu_out = op_a;
      OP_ACC:  alu_out = acc_q + op_a;
      OP_MAX:  alu_out = (op_a > op_b) ? op_a : op_b;
      OP_MIN:  alu_out = (op_a < op_b) ? op_a : op_b;
      default: alu_out = '0;
    endcase
  end

  // A new configuration always starts the accumulation from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (conf_we) begin
      acc_q <= '0;
    end else if (!stall && cfg_alu == OP_ACC) begin
      acc_q <= alu_out;
    end
  end

  // Stage: DL_NN delay line
  assign dl_sat = sat_dl(cfg_dl);

  always_comb begin
    dl_out = alu_out;
    for (int k = 1; k <= DL_DEPTH; k++) begin
      if (dl_sat == DLW'(k)) dl_out = dl_q[k-1];
    end
  end

  // Stage: switch element feeding the doors
  assign door_in[D_N]   = se_mux(cfg_se[1:0], alu_out, IN_SOUTH, IN_CONST_A);
  assign door_in[D_S]   = se_mux(cfg_se[3:2], alu_out, IN_NORTH, IN_CONST_A);
  assign door_in[D_E]   = se_mux(cfg_se[5:4], alu_out, IN_WEST,  IN_CONST_A);
  assign door_in[D_W]   = se_mux(cfg_se[7:6], alu_out, IN_EAST,  IN_CONST_A);
  assign door_in[D_DLN] = alu_out;
  assign door_in[D_DNN] = dl_out;

  // Stage: door registers p0..p2 and delay line; conf_we flush wins over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_p0 <= '0;
      door_p1 <= '0;
      door_p2 <= '0;
      dl_q    <= '0;
    end else if (conf_we) begin
      door_p0 <= '0;
      door_p1 <= '0;
      door_p2 <= '0;
      dl_q    <= '0;
    end else if (!stall) begin
      door_p0 <= door_in;
      door_p1 <= door_p0;
      door_p2 <= door_p1;
      dl_q[0] <= alu_out;
      for (int k = 1; k < DL_DEPTH; k++) begin
        dl_q[k] <= dl_q[k-1];
      end
    end
  end

  // Stage: door output taps
  always_comb begin
    door_out = '0;
    for (int i = 0; i < NDOOR; i++) begin
      door_out[i] = door_tap(cfg_dr[2*i +: 2], door_in[i], door_p0[i], door_p1[i], door_p2[i]);
    end
  end

  assign OUT_NORTH = door_out[D_N];
  assign OUT_SOUTH = door_out[D_S];
  assign OUT_EAST  = door_out[D_E];
  assign OUT_WEST  = door_out[D_W];
  assign OUT_DL_N  = door_out[D_DLN];
  assign OUT_DL_NN = door_out[D_DNN];
  assign OUT_DL_E  = alu_out;

endmodule

// File: tb/tb_pe_dr_param.sv
// Scoreboard bench for pe_dr_param: stimulus queues expected outputs tagged with the cycle
// they must appear in; a monitor compares them mid-cycle (or on demand for async reset checks).
module tb_pe_dr_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        conf_we;
  logic [3:0]  conf_alu;
  logic [2:0]  conf_sel_a;
  logic [2:0]  conf_sel_b;
  logic [7:0]  conf_se;
  logic [11:0] conf_dr;
  logic [2:0]  conf_dl;
  logic [15:0] IN_NORTH, IN_SOUTH, IN_EAST, IN_WEST, IN_DL_S, IN_DL_W, IN_DL_SS;
  logic [15:0] IN_CONST_A, IN_CONST_B;
  logic [15:0] OUT_NORTH, OUT_SOUTH, OUT_EAST, OUT_WEST, OUT_DL_N, OUT_DL_E, OUT_DL_NN;

  pe_dr_param #(.DATA_W(16), .DL_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .conf_we(conf_we),
    .conf_alu(conf_alu), .conf_sel_a(conf_sel_a), .conf_sel_b(conf_sel_b),
    .conf_se(conf_se), .conf_dr(conf_dr), .conf_dl(conf_dl),
    .IN_NORTH(IN_NORTH), .IN_SOUTH(IN_SOUTH), .IN_EAST(IN_EAST), .IN_WEST(IN_WEST),
    .IN_DL_S(IN_DL_S), .IN_DL_W(IN_DL_W), .IN_DL_SS(IN_DL_SS),
    .IN_CONST_A(IN_CONST_A), .IN_CONST_B(IN_CONST_B),
    .OUT_NORTH(OUT_NORTH), .OUT_SOUTH(OUT_SOUTH), .OUT_EAST(OUT_EAST), .OUT_WEST(OUT_WEST),
    .OUT_DL_N(OUT_DL_N), .OUT_DL_E(OUT_DL_E), .OUT_DL_NN(OUT_DL_NN)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          port;
    logic [15:0] exp;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  event mon_ev;
  logic [15:0] got;

  localparam int P_N = 0, P_S = 1, P_E = 2, P_W = 3, P_DLN = 4, P_DLE = 5, P_DNN = 6;

  function automatic string pname(input int p);
    case (p)
      P_N:     return "OUT_NORTH";
      P_S:     return "OUT_SOUTH";
      P_E:     return "OUT_EAST";
      P_W:     return "OUT_WEST";
      P_DLN:   return "OUT_DL_N";
      P_DLE:   return "OUT_DL_E";
      default: return "OUT_DL_NN";
    endcase
  endfunction

  function automatic logic [15:0] outv(input int p);
    case (p)
      P_N:     return OUT_NORTH;
      P_S:     return OUT_SOUTH;
      P_E:     return OUT_EAST;
      P_W:     return OUT_WEST;
      P_DLN:   return OUT_DL_N;
      P_DLE:   return OUT_DL_E;
      default: return OUT_DL_NN;
    endcase
  endfunction

  // Monitor: compare every entry due this cycle; anything older was missed.
  always begin
    @(negedge clk or mon_ev);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        checks++;
        got = outv(sb[i].port);
        if (sb[i].due < cyc) begin
          errors++;
          $display("FAIL %s missed check due cycle %0d (now %0d) want %h",
                   pname(sb[i].port), sb[i].due, cyc, sb[i].exp);
        end else if (got !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cycle %0d got %h want %h", pname(sb[i].port), cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_out(input int due, input int port, input logic [15:0] v);
    sb.push_back('{due, port, v});
  endtask

  task automatic expect_all_zero();
    for (int p = 0; p < 7; p++) expect_out(cyc, p, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    IN_NORTH = 16'($urandom); IN_SOUTH = 16'($urandom); IN_EAST = 16'($urandom);
    IN_WEST  = 16'($urandom); IN_DL_S  = 16'($urandom); IN_DL_W = 16'($urandom);
    IN_DL_SS = 16'($urandom); IN_CONST_A = 16'($urandom); IN_CONST_B = 16'($urandom);
  endtask

  task automatic cfg(input logic [3:0] alu, input logic [2:0] sa, input logic [2:0] sbs,
                     input logic [7:0] se, input logic [11:0] dr, input logic [2:0] dl,
                     input logic stl);
    conf_alu = alu; conf_sel_a = sa; conf_sel_b = sbs;
    conf_se = se; conf_dr = dr; conf_dl = dl;
    conf_we = 1'b1; stall = stl;
    tick();
    conf_we = 1'b0; stall = 1'b0;
    conf_alu = '0; conf_sel_a = '0; conf_sel_b = '0; conf_se = '0; conf_dr = '0; conf_dl = '0;
  endtask

  task automatic apply_add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    IN_SOUTH = a; IN_EAST = b;
    expect_out(cyc, P_DLE, s);
    expect_out(cyc, P_DLN, s);
    expect_out(cyc, P_DNN, s);
    expect_out(cyc + 2, P_N, s);
    tick();
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r);
    cfg(op, 3'd6, 3'd7, 8'h00, 12'h000, 3'd0, 1'b0);
    IN_CONST_A = a; IN_CONST_B = b;
    expect_out(cyc, P_DLE, r);
    expect_out(cyc, P_DNN, r);
    tick();
  endtask

  bit   [9:0]  st_acc = 10'b00_1111_0000;
  logic [15:0] ss_in  [9] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd5, 16'd6, 16'd7};
  bit          ss_st  [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  logic [15:0] ss_exp [9] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4};

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] accv, dn;
    rst = 1'b1; stall = 1'b0; conf_we = 1'b0;
    conf_alu = '0; conf_sel_a = '0; conf_sel_b = '0; conf_se = '0; conf_dr = '0; conf_dl = '0;
    rand_inputs();

    // Reset: all outputs zero asynchronously and with the all-zero config afterwards
    #2;
    expect_all_zero();
    -> mon_ev;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rand_inputs();
    tick();
    expect_all_zero();
    tick();

    // ADD S+E, N via ALU with door 2; DL_N and DL_NN bypass
    cfg(4'd1, 3'd0, 3'd1, 8'h01, 12'h002, 3'd0, 1'b0);
    expect_out(cyc, P_N, 16'h0000);
    expect_out(cyc + 1, P_N, 16'h0000);
    expect_out(cyc, P_S, 16'h0000);
    apply_add(16'd5, 16'd7, 16'd12);
    apply_add(16'hFFFF, 16'h0002, 16'h0001);
    apply_add(16'h1234, 16'h0001, 16'h1235);
    apply_add(16'h8000, 16'h8000, 16'h0000);
    tick(); tick();

    // Switch codes: N zero, S pass IN_NORTH (door 1), E CONST_A, W pass IN_EAST
    cfg(4'd0, 3'd0, 3'd0, 8'hB8, 12'h004, 3'd0, 1'b0);
    IN_NORTH = 16'h1234; IN_EAST = 16'h0BEE; IN_CONST_A = 16'h00C0;
    expect_out(cyc, P_N, 16'h0000);
    expect_out(cyc, P_S, 16'h0000);
    expect_out(cyc, P_E, 16'h00C0);
    expect_out(cyc, P_W, 16'h0BEE);
    expect_out(cyc + 1, P_S, 16'h1234);
    tick(); tick();

    // ALU opcode table on CONST_A / CONST_B
    alu_chk(4'd3,  16'h0100, 16'h0100, 16'h0000);
    alu_chk(4'd3,  16'h0003, 16'h0005, 16'h000F);
    alu_chk(4'd2,  16'h0003, 16'h0005, 16'hFFFE);
    alu_chk(4'd9,  16'h8000, 16'h0003, 16'hF000);
    alu_chk(4'd8,  16'h8000, 16'h0003, 16'h1000);
    alu_chk(4'd7,  16'h0001, 16'h0014, 16'h0010);
    alu_chk(4'd4,  16'hF0F0, 16'h3C3C, 16'h3030);
    alu_chk(4'd5,  16'hF0F0, 16'h3C3C, 16'hFCFC);
    alu_chk(4'd6,  16'hF0F0, 16'h3C3C, 16'hCCCC);
    alu_chk(4'd12, 16'hFFFE, 16'h0003, 16'h0003);
    alu_chk(4'd13, 16'hFFFE, 16'h0003, 16'hFFFE);
    alu_chk(4'd10, 16'hABCD, 16'h0000, 16'hABCD);
    alu_chk(4'd0,  16'h1234, 16'h5678, 16'h0000);
    alu_chk(4'd14, 16'h1234, 16'h5678, 16'h0000);

    // Accumulate CONST_A=3, DL_N door 1, stall for 4 cycles in the middle
    cfg(4'd11, 3'd6, 3'd0, 8'h01, 12'h100, 3'd0, 1'b0);
    IN_CONST_A = 16'd3;
    accv = 16'd0; dn = 16'd0;
    for (int i = 0; i < 10; i++) begin
      stall = st_acc[i];
      expect_out(cyc, P_DLE, accv + 16'd3);
      expect_out(cyc, P_N, accv + 16'd3);
      expect_out(cyc, P_DLN, dn);
      tick();
      if (!st_acc[i]) begin
        dn = accv + 16'd3;
        accv = accv + 16'd3;
      end
    end
    stall = 1'b0;
    cfg(4'd11, 3'd6, 3'd0, 8'h01, 12'h100, 3'd0, 1'b1);
    expect_out(cyc, P_DLE, 16'd3);
    expect_out(cyc, P_DLN, 16'd0);
    tick();
    expect_out(cyc, P_DLE, 16'd6);
    expect_out(cyc, P_DLN, 16'd3);
    tick();

    // DL_NN: depth 7 saturates to 4, plus door 1 -> impulse after 5 edges
    cfg(4'd10, 3'd6, 3'd0, 8'h00, 12'h400, 3'd7, 1'b0);
    IN_CONST_A = 16'h00AA;
    expect_out(cyc, P_DNN, 16'h0000);
    expect_out(cyc, P_DLE, 16'h00AA);
    tick();
    IN_CONST_A = 16'h0000;
    for (int i = 1; i <= 6; i++) begin
      expect_out(cyc, P_DNN, (i == 5) ? 16'h00AA : 16'h0000);
      tick();
    end

    // Counter stream through N door 3 with a mid-stream stall
    cfg(4'd10, 3'd6, 3'd0, 8'h01, 12'h003, 3'd0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      IN_CONST_A = ss_in[j];
      stall = ss_st[j];
      expect_out(cyc, P_N, ss_exp[j]);
      expect_out(cyc, P_DLE, ss_in[j]);
      tick();
    end
    stall = 1'b0;
    // conf_we together with stall still flushes every door stage
    cfg(4'd10, 3'd6, 3'd0, 8'h01, 12'h003, 3'd0, 1'b1);
    IN_CONST_A = 16'h0055;
    for (int j = 0; j < 4; j++) begin
      expect_out(cyc, P_N, (j == 3) ? 16'h0055 : 16'h0000);
      if (j < 3) tick();
    end

    // Mid-operation reset: outputs drop with no clock edge
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_all_zero();
    -> mon_ev;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_inputs();
    expect_all_zero();
    tick();
    rand_inputs();
    expect_all_zero();
    tick();

    for (int i = 0; i < 3 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked, due cycle %0d want %h",
               pname(sb[0].port), sb[0].due, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
